rv32zhinx_issue: RTL and testbench
==================================

RV32ZHINX_ISSUE -- requirements
Module: rv32zhinx_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, >=2), request FIFO entry count.
REQ-002 SHALL have parameter TAG_W, default 5, request/response tag width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only per REQ-027).
REQ-004 SHALL have port CLK input 1: sole clock, rising edge.
REQ-005 SHALL have port RST input 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports req_valid input 1 and req_ready output 1: request handshake.
REQ-007 SHALL have ports req_op input fpu_operation_t, req_a input WORD_W, req_b input WORD_W, req_tag input TAG_W: request payload.
REQ-008 SHALL have ports fpu_start output 1, fpu_operation output fpu_operation_t, fpu_a output WORD_W, fpu_b output WORD_W: drive to FPU unit.
REQ-009 SHALL have ports fpu_done input 1 and fpu_out input WORD_W: FPU completion and result.
REQ-010 SHALL have ports rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-011 SHALL have ports rsp_data output WORD_W, rsp_tag output TAG_W, rsp_err output 1: response payload.
REQ-012 SHALL have port busy output 1: high when state is not IDLE or FIFO non-empty.

Function
REQ-013 SHALL push {op,a,b,tag} into the FIFO on the rising edge where req_valid && req_ready.
REQ-014 SHALL drive req_ready = !full; a push is refused when full even if a pop occurs the same cycle.
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: if FIFO non-empty, pop head into holding registers and enter BUSY next edge; else stay.
REQ-017 BUSY: fpu_start=1; fpu_operation/fpu_a/fpu_b equal holding registers, stable for the whole state.
REQ-018 BUSY: on any edge with fpu_done=1, capture fpu_out into rsp_data, set rsp_err=0 and enter RESP; fpu_done is sampled only while fpu_start=1.
REQ-019 RESP: rsp_valid=1 and rsp_data/rsp_tag/rsp_err held until rsp_valid && rsp_ready.
REQ-020 RESP handshake: if FIFO non-empty, pop and enter BUSY; else enter IDLE.
REQ-021 SHALL drive fpu_start=0 in IDLE and RESP; operand outputs keep the last holding-register values.
REQ-022 With FPU done asserted combinationally, accept at edge t yields fpu_start high in cycle t+2 and rsp_valid high in cycle t+3.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; count is 0..DEPTH, with full at DEPTH and empty at 0.
REQ-024 Responses SHALL be returned in request order with the tag unchanged.

Reset
REQ-025 RST=1 SHALL immediately clear: state=IDLE, FIFO empty, fpu_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tag=0, holding registers 0 (fpu_operation=FPU_HALF_ADD), req_ready=1, busy=0.
REQ-026 Reset asserted mid-BUSY or mid-RESP SHALL discard the in-flight and queued requests, with no response issued.

Configuration
REQ-027 With RV32ZHINX_ISSUE_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle without done; if it reaches TIMEOUT_CYCLES, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-028 Without RV32ZHINX_ISSUE_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-029 Reset, then a single FPU_HALF_ADD request with a=0x3C00, b=0x3C00, tag=3, and done tied 1 -> rsp_valid in cycle t+3, rsp_data=0x00004000, rsp_tag=3, rsp_err=0.
REQ-030 Push 5 requests with DEPTH=4 and rsp_ready=0 -> req_ready drops after the FIFO fills; all responses emerge in order with tags 0..4 once rsp_ready=1.
REQ-031 Hold fpu_done=0 for 7 BUSY cycles then 1 -> fpu_start stays high with stable operands for 8 cycles, and a single response is issued.
REQ-032 Assert RST during BUSY with 2 entries queued -> fpu_start=0, rsp_valid=0, req_ready=1 immediately, with no response after release.
REQ-033 With the macro defined and fpu_done held 0 -> after 16 BUSY cycles, rsp_err=1 and rsp_data=0; without the macro, BUSY persists for 100 cycles.
REQ-034 Back-to-back: two queued requests with rsp_ready=1 -> the second fpu_start is asserted the cycle after the first response handshake.

Source files
------------

// File: rtl/rv32zhinx_issue_pkg.sv
// rv32zhinx_issue_pkg: shared types for the Zhinx FPU issue block.
//   WORD_W          - operand/result width (half values live in x-registers)
//   fpu_operation_t - operation code presented to the FPU unit
package rv32zhinx_issue_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    FPU_HALF_ADD  = 3'd0,
    FPU_HALF_SUB  = 3'd1,
    FPU_HALF_MUL  = 3'd2,
    FPU_HALF_DIV  = 3'd3,
    FPU_HALF_SQRT = 3'd4,
    FPU_HALF_MIN  = 3'd5,
    FPU_HALF_MAX  = 3'd6,
    FPU_HALF_CMP  = 3'd7
  } fpu_operation_t;

endpackage

// File: rtl/rv32zhinx_issue.sv
// rv32zhinx_issue: queues FPU requests in a DEPTH-entry FIFO and issues them
// one at a time to a half-precision FPU, returning responses in request order.
//   CLK, RST                       - clock (rising edge), async active-high reset
//   req_valid/req_ready            - request handshake
//   req_op/req_a/req_b/req_tag     - request payload
//   fpu_start/fpu_operation/fpu_a/fpu_b - drive to FPU (held for the whole op)
//   fpu_done/fpu_out               - FPU completion and result
//   rsp_valid/rsp_ready            - response handshake
//   rsp_data/rsp_tag/rsp_err       - response payload
//   busy                           - FSM not idle or FIFO non-empty
// Optional feature: define RV32ZHINX_ISSUE_TIMEOUT_EN to enable a watchdog that
// ends a stalled FPU operation after TIMEOUT_CYCLES with rsp_err=1, rsp_data=0.
module rv32zhinx_issue
  import rv32zhinx_issue_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  fpu_operation_t       req_op,
  input  logic [WORD_W-1:0]    req_a,
  input  logic [WORD_W-1:0]    req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 fpu_start,
  output fpu_operation_t       fpu_operation,
  output logic [WORD_W-1:0]    fpu_a,
  output logic [WORD_W-1:0]    fpu_b,
  input  logic                 fpu_done,
  input  logic [WORD_W-1:0]    fpu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_W-1:0]    rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;

  fpu_operation_t     fifo_op  [DEPTH];
  logic [WORD_W-1:0]  fifo_a   [DEPTH];
  logic [WORD_W-1:0]  fifo_b   [DEPTH];
  logic [TAG_W-1:0]   fifo_tag [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  fpu_operation_t     hold_op;
  logic [WORD_W-1:0]  hold_a, hold_b;
  logic [TAG_W-1:0]   hold_tag;

  logic full, empty, push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  // Ready depends only on the current count, so a same-cycle pop never frees a slot.
  assign push      = req_valid && !full;
  // The head leaves the FIFO when the FSM moves into BUSY: from IDLE, or
  // straight out of RESP on the response handshake.
  assign pop       = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

  assign fpu_start     = (state == BUSY);
  assign rsp_valid     = (state == RESP);
  assign fpu_operation = hold_op;
  assign fpu_a         = hold_a;
  assign fpu_b         = hold_b;
  assign busy          = (state != IDLE) || !empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_op[wr_ptr]  <= req_op;
      fifo_a[wr_ptr]   <= req_a;
      fifo_b[wr_ptr]   <= req_b;
      fifo_tag[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      hold_op  <= FPU_HALF_ADD;
      hold_a   <= '0;
      hold_b   <= '0;
      hold_tag <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
      rsp_err  <= 1'b0;
      tmo_cnt  <= '0;
`endif
    end else begin
      if (pop) begin
        hold_op  <= fifo_op[rd_ptr];
        hold_a   <= fifo_a[rd_ptr];
        hold_b   <= fifo_b[rd_ptr];
        hold_tag <= fifo_tag[rd_ptr];
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
        tmo_cnt  <= '0;
`endif
      end
      case (state)
        IDLE: if (!empty) state <= BUSY;
        BUSY: begin
          if (fpu_done) begin
            rsp_data <= fpu_out;
            rsp_tag  <= hold_tag;
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
            rsp_err  <= 1'b0;
`endif
            state    <= RESP;
          end
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
          // This edge closes the TIMEOUT_CYCLES-th BUSY cycle without done.
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data <= '0;
            rsp_tag  <= hold_tag;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: if (rsp_ready) state <= empty ? IDLE : BUSY;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32zhinx_issue.sv
// tb_rv32zhinx_issue: scoreboard bench for rv32zhinx_issue. A stand-in FPU
// answers with a fixed operand-dependent result after a programmable delay;
// each accepted request queues its expected response, and a monitor pops and
// compares on every response handshake.
module tb_rv32zhinx_issue;
  import rv32zhinx_issue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned TMO   = 16;
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  fpu_operation_t    req_op = FPU_HALF_ADD;
  logic [31:0]       req_a = '0, req_b = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              fpu_start;
  fpu_operation_t    fpu_operation;
  logic [31:0]       fpu_a, fpu_b, fpu_out;
  logic              fpu_done;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err, busy;

  always #5 CLK = ~CLK;

  rv32zhinx_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  int total = 0, bad = 0, rsp_count = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Stand-in FPU: exact for ADD of two equal normal halves (doubling bumps the
  // exponent), otherwise an arbitrary pattern that depends on every operand bit.
  function automatic logic [31:0] fpu_stub(fpu_operation_t op, logic [31:0] a, logic [31:0] b);
    if (op == FPU_HALF_ADD && a == b) return a + 32'h0000_0400;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {29'd0, op};
  endfunction

  function automatic fpu_operation_t rand_op();
    return fpu_operation_t'($urandom_range(0, 7));
  endfunction

  int done_after    = 0;    // BUSY cycles without done before done rises
  bit stall_forever = 1'b0;
  int stall_cnt     = 0;

  assign fpu_done = fpu_start && !stall_forever && (stall_cnt >= done_after);
  assign fpu_out  = fpu_stub(fpu_operation, fpu_a, fpu_b);

  always @(posedge CLK or posedge RST)
    if (RST) stall_cnt <= 0;
    else if (fpu_start && !fpu_done) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];
  exp_t push_e, mon_e;

  always @(posedge CLK)
    if (!RST && req_valid && req_ready) begin
      push_e.tag = req_tag;
      if (TMO_EN && stall_forever) begin
        push_e.data = '0;
        push_e.err  = 1'b1;
      end else begin
        push_e.data = fpu_stub(req_op, req_a, req_b);
        push_e.err  = 1'b0;
      end
      sb.push_back(push_e);
    end

  always @(negedge CLK)
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got response tag %0h, expected none", rsp_tag);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_tag", 64'(rsp_tag), 64'(mon_e.tag));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(fpu_operation_t op, logic [31:0] a, logic [31:0] b,
                      logic [TAG_W-1:0] tag, bit rand_rdy);
    bit acc = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    while (!acc && n < 100) begin
      @(negedge CLK);
      acc = req_ready;
      tick();
      n++;
      if (rand_rdy) begin
        rsp_ready  = 1'($urandom_range(0, 1));
        done_after = $urandom_range(0, 3);
      end
    end
    req_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %0h not accepted, expected acceptance within 100 cycles", tag);
    end
  endtask

  task automatic wait_rsp(int target, int budget, string name);
    int n = 0;
    while (rsp_count < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(rsp_count), 64'(target));
  endtask

  task automatic wait_start(string name);
    int n = 0;
    while (!fpu_start && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(fpu_start), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base, cycles;
    bit stable;
    fpu_operation_t op;
    logic [31:0] a, b, b2;

    // Reset values, checked while reset is held.
    #2 RST = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst_fpu_op", 64'(fpu_operation), 64'(FPU_HALF_ADD));
    check("rst_fpu_a", 64'(fpu_a), 64'd0);
    check("rst_fpu_b", 64'(fpu_b), 64'd0);
    tick();
    RST = 1'b0;
    tick();

    // Single request, done tied high: start at t+2, response at t+3.
    rsp_ready = 1'b1; done_after = 0;
    send(FPU_HALF_ADD, 32'h3C00, 32'h3C00, 5'd3, 1'b0);
    check("lat_start_t1", 64'(fpu_start), 64'd0);
    tick();
    check("lat_start_t2", 64'(fpu_start), 64'd1);
    check("lat_valid_t2", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_valid_t3", 64'(rsp_valid), 64'd1);
    check("lat_data", 64'(rsp_data), 64'h4000);
    check("lat_tag", 64'(rsp_tag), 64'd3);
    tick();
    check("lat_idle_after", 64'(busy), 64'd0);

    // Five requests with responses blocked: FIFO fills, then drains in order.
    rsp_ready = 1'b0; base = rsp_count;
    for (int i = 0; i < 5; i++) send(rand_op(), $urandom, $urandom, 5'(i), 1'b0);
    tick();
    check("full_ready_low", 64'(req_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    req_valid = 1'b1; req_tag = 5'd31;
    repeat (3) begin
      @(negedge CLK);
      check("full_refuse", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(base + 5, 60, "full_drain");

    // Seven stall cycles then done: eight cycles of stable issue, one response.
    done_after = 7; base = rsp_count;
    op = rand_op(); a = $urandom; b = $urandom;
    send(op, a, b, 5'd7, 1'b0);
    wait_start("stall_start");
    cycles = 0; stable = 1'b1;
    while (fpu_start && cycles < 50) begin
      if (fpu_operation != op || fpu_a != a || fpu_b != b) stable = 1'b0;
      cycles++;
      tick();
    end
    check("stall_cycles", 64'(cycles), 64'd8);
    check("stall_stable", 64'(stable), 64'd1);
    wait_rsp(base + 1, 10, "stall_rsp");
    repeat (3) tick();
    check("stall_single_rsp", 64'(rsp_count), 64'(base + 1));
    check("stall_ops_kept", 64'(fpu_a), 64'(a));

    // Back-to-back: second start in the cycle after the first handshake.
    done_after = 0; base = rsp_count;
    b2 = $urandom;
    send(FPU_HALF_MUL, 32'h1111, 32'h2222, 5'd10, 1'b0);
    send(FPU_HALF_SUB, 32'h3333, b2, 5'd11, 1'b0);
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("b2b_first_tag", 64'(rsp_tag), 64'd10);
    tick();
    check("b2b_second_start", 64'(fpu_start), 64'd1);
    check("b2b_second_b", 64'(fpu_b), 64'(b2));
    wait_rsp(base + 2, 20, "b2b_rsp");

    // Reset mid-BUSY with two queued: everything discarded.
    stall_forever = 1'b1; base = rsp_count;
    send(FPU_HALF_DIV, 32'hAAAA, 32'h5555, 5'd20, 1'b0);
    send(FPU_HALF_DIV, 32'hBBBB, 32'h6666, 5'd21, 1'b0);
    send(FPU_HALF_DIV, 32'hCCCC, 32'h7777, 5'd22, 1'b0);
    check("rst_mid_busy_pre", 64'(fpu_start), 64'd1);
    #2 RST = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_start", 64'(fpu_start), 64'd0);
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    tick();
    RST = 1'b0; stall_forever = 1'b0;
    repeat (20) tick();
    check("rst_mid_no_rsp", 64'(rsp_count), 64'(base));
    check("rst_mid_idle", 64'(busy), 64'd0);

    // FPU never completes.
    stall_forever = 1'b1; base = rsp_count;
    send(FPU_HALF_SQRT, 32'h4400, 32'h0, 5'd9, 1'b0);
    wait_start("hang_start");
    cycles = 0;
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
    while (fpu_start && cycles < 200) begin
      cycles++;
      tick();
    end
    check("tmo_busy_cycles", 64'(cycles), 64'(TMO));
    check("tmo_valid", 64'(rsp_valid), 64'd1);
    check("tmo_err", 64'(rsp_err), 64'd1);
    check("tmo_data", 64'(rsp_data), 64'd0);
    stall_forever = 1'b0;
    wait_rsp(base + 1, 10, "tmo_rsp");
`else
    repeat (100) begin
      if (fpu_start && !rsp_valid) cycles++;
      tick();
    end
    check("hang_busy_cycles", 64'(cycles), 64'd100);
    stall_forever = 1'b0;
    wait_rsp(base + 1, 10, "hang_release_rsp");
`endif

    // Randomized traffic with random backpressure and FPU latency.
    base = rsp_count;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        rsp_ready = 1'($urandom_range(0, 1));
      end
      send(rand_op(), $urandom, $urandom, 5'($urandom), 1'b1);
    end
    rsp_ready = 1'b1; done_after = 0;
    wait_rsp(base + 40, 400, "rand_drain");
    tick();
    check("final_idle", 64'(busy), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
